alu_issue_ctrl: RTL and testbench
=================================

# alu_issue_ctrl

Multi-cycle issue controller sitting directly upstream of the ALU: accepts one decoded operation at a time, selects and registers the ALU operands, drives the 5-bit ALU selector, and captures the ALU result. It sequences the two-phase BLEU operation (target add, then compare-subtract) and holds the result with a valid/ready handshake toward writeback/branch logic.

## Interface
- No parameters; all widths are fixed at 32-bit data, 16-bit immediate, 4-bit opcode.
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high; returns block to IDLE
- op_valid  in  1  upstream has an operation
- op_ready  out  1  block can accept (high only in IDLE)
- op_code  in  4  0 ADD, 1 LW, 2 SW, 3 NOR, 4 NORI, 5 NOT, 6 ROLV, 7 RORV, 8 BLEU; 9-15 illegal
- rs_val, rt_val  in  32  register operands
- imm  in  16  immediate
- pc  in  32  PC of the operation
- alu_i1, alu_i2  out  32  ALU operand inputs
- alu_sel  out  5  ALU selector
- alu_o  in  32  ALU result (combinational from alu_i1/alu_i2/alu_sel)
- res_valid  out  1  result held
- res_ready  in  1  downstream consumes result
- res_data  out  32  captured ALU result (0 for BLEU and illegal)
- res_is_branch  out  1  result is a BLEU
- branch_taken  out  1  BLEU condition true
- branch_target  out  32  pc + sext(imm)
- res_err  out  1  illegal opcode

## Operation
- States: IDLE, EXEC, BR2, DONE.
- IDLE: op_ready=1. On op_valid: register op_code and the operand pair below, go EXEC (legal) or DONE with res_err=1, res_data=0 (illegal).
- Operand registers: ADD/NOR: i1=rs, i2=rt. LW/SW: i1=rs, i2=sext(imm). NORI: i1=rs, i2=zext(imm). NOT: i1=0, i2=rt. ROLV/RORV: i1=rs (ALU uses i1[2:0] as amount), i2=rt. BLEU: i1=pc, i2=sext(imm); rs/rt also registered for phase 2.
- alu_sel in EXEC: ADD 10000, LW 10001, SW 10101, NOR 10011, NORI 00111, NOT 00010, ROLV 00000, RORV 00001, BLEU 01000.
- EXEC, non-BLEU: capture alu_o into res_data, go DONE.
- EXEC, BLEU: capture alu_o into branch_target, load i1=rs, i2=rt, go BR2.
- BR2: alu_sel=01001; branch_taken <= alu_o[31] | (alu_o==0); res_data <= 0; res_is_branch <= 1; go DONE.
- DONE: res_valid=1, outputs stable; on res_ready go IDLE. No accept in the same cycle as the DONE->IDLE transition.
- IDLE and DONE: alu_sel=11111 (matches no ALU function, ALU output 0), alu_i1=alu_i2=0.
- Flags (res_err, res_is_branch, branch_taken) cleared on every accept.

## Timing
- Reset (async, immediate): state IDLE; op_ready=1; res_valid, res_data, res_is_branch, branch_taken, branch_target, res_err all 0; alu_sel=11111; alu_i1=alu_i2=0.
- Accept at edge E0. Non-BLEU: res_valid high after E1 (latency 2 edges). BLEU: after E2 (3 edges). Illegal: after E0 (1 edge).
- Throughput: one op per latency+1 cycles minimum (DONE always costs one cycle).
- res_valid held high with all result outputs unchanged until res_ready is sampled high; res_ready while not DONE is ignored.
- op_valid while op_ready=0 is ignored; upstream must hold.
- Reset asserted mid-EXEC/BR2/DONE discards the operation; no result is produced.
- All additions wrap modulo 2^32; sext replicates imm[15], zext pads zeros.

## Test plan
- Reset then ADD rs=5, rt=7 -> op_ready=1 after reset; alu_sel=10000 in EXEC; res_valid after 2 edges, res_data=12, res_err=0.
- LW rs=0x1000, imm=0xFFFC -> alu_i2=0xFFFFFFFC, res_data=0x00000FFC; SW same operands gives alu_sel=10101, same res_data.
- ROLV rs=3, rt=0x80000001 -> res_data=0x0000000C; RORV same -> res_data=0x30000000; NOT rt=0 -> 0xFFFFFFFF.
- BLEU pc=0x100, imm=0x0010, rs=4, rt=4 -> alu_sel 01000 then 01001; after 3 edges branch_target=0x110, branch_taken=1, res_is_branch=1; rs=9, rt=4 -> branch_taken=0.
- Illegal op_code=12 -> res_valid after 1 edge, res_err=1, res_data=0; hold res_ready=0 for 5 cycles -> outputs stable, op_ready=0 throughout.
- Assert reset in BR2 of a BLEU -> res_valid never rises, all outputs at reset values, next ADD completes normally.

Source files
------------

// File: rtl/alu_issue_ctrl.sv
// Issue controller in front of the ALU: registers operands, drives the ALU selector,
// sequences the two-phase BLEU and holds the result under a valid/ready handshake.
module alu_issue_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic        op_valid,
    output logic        op_ready,
    input  logic [3:0]  op_code,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic [15:0] imm,
    input  logic [31:0] pc,
    output logic [31:0] alu_i1,
    output logic [31:0] alu_i2,
    output logic [4:0]  alu_sel,
    input  logic [31:0] alu_o,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [31:0] res_data,
    output logic        res_is_branch,
    output logic        branch_taken,
    output logic [31:0] branch_target,
    output logic        res_err
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are both high.
    // op_ready is high only in IDLE; res_valid is high only in DONE and everything it
    // qualifies stays frozen until res_ready is sampled.

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        BR2  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_LW   = 4'd1;
    localparam logic [3:0] OP_SW   = 4'd2;
    localparam logic [3:0] OP_NOR  = 4'd3;
    localparam logic [3:0] OP_NORI = 4'd4;
    localparam logic [3:0] OP_NOT  = 4'd5;
    localparam logic [3:0] OP_ROLV = 4'd6;
    localparam logic [3:0] OP_RORV = 4'd7;
    localparam logic [3:0] OP_BLEU = 4'd8;

    localparam logic [4:0] SEL_IDLE = 5'b11111;
    localparam logic [4:0] SEL_CMP  = 5'b01001;

    state_t      state;
    state_t      state_nx;
    logic [3:0]  op_q;
    logic [31:0] i1_q;
    logic [31:0] i2_q;
    logic [31:0] rs_q;
    logic [31:0] rt_q;

    logic        accept;
    logic        op_legal;
    logic [31:0] imm_sext;
    logic [31:0] imm_zext;
    logic [31:0] opnd_i1;
    logic [31:0] opnd_i2;

    assign accept   = (state == IDLE) && op_valid;
    assign op_legal = (op_code <= OP_BLEU);
    assign imm_sext = {{16{imm[15]}}, imm};
    assign imm_zext = {16'h0000, imm};

    always_comb begin
        opnd_i1 = rs_val;
        opnd_i2 = rt_val;
        case (op_code)
            OP_LW, OP_SW: opnd_i2 = imm_sext;
            OP_NORI:      opnd_i2 = imm_zext;
            OP_NOT:       opnd_i1 = '0;
            OP_BLEU: begin
                opnd_i1 = pc;
                opnd_i2 = imm_sext;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (op_valid) state_nx = op_legal ? EXEC : DONE;
            EXEC: state_nx = (op_q == OP_BLEU) ? BR2 : DONE;
            BR2:  state_nx = DONE;
            DONE: if (res_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Operands are gated to zero outside EXEC/BR2 so the ALU sees a quiet input.
    always_comb begin
        op_ready  = 1'b0;
        res_valid = 1'b0;
        alu_sel   = SEL_IDLE;
        alu_i1    = '0;
        alu_i2    = '0;
        case (state)
            IDLE: op_ready = 1'b1;
            EXEC: begin
                alu_i1 = i1_q;
                alu_i2 = i2_q;
                case (op_q)
                    OP_ADD:  alu_sel = 5'b10000;
                    OP_LW:   alu_sel = 5'b10001;
                    OP_SW:   alu_sel = 5'b10101;
                    OP_NOR:  alu_sel = 5'b10011;
                    OP_NORI: alu_sel = 5'b00111;
                    OP_NOT:  alu_sel = 5'b00010;
                    OP_ROLV: alu_sel = 5'b00000;
                    OP_RORV: alu_sel = 5'b00001;
                    OP_BLEU: alu_sel = 5'b01000;
                    default: alu_sel = SEL_IDLE;
                endcase
            end
            BR2: begin
                alu_i1  = i1_q;
                alu_i2  = i2_q;
                alu_sel = SEL_CMP;
            end
            DONE: res_valid = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_q          <= '0;
            i1_q          <= '0;
            i2_q          <= '0;
            rs_q          <= '0;
            rt_q          <= '0;
            res_data      <= '0;
            res_is_branch <= 1'b0;
            branch_taken  <= 1'b0;
            branch_target <= '0;
            res_err       <= 1'b0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    op_q          <= op_code;
                    i1_q          <= opnd_i1;
                    i2_q          <= opnd_i2;
                    rs_q          <= rs_val;
                    rt_q          <= rt_val;
                    res_data      <= '0;
                    res_is_branch <= 1'b0;
                    branch_taken  <= 1'b0;
                    branch_target <= '0;
                    res_err       <= ~op_legal;
                end
                EXEC: begin
                    if (op_q == OP_BLEU) begin
                        // Phase 1 result is the target; phase 2 compares rs against rt.
                        branch_target <= alu_o;
                        i1_q          <= rs_q;
                        i2_q          <= rt_q;
                    end else begin
                        res_data <= alu_o;
                    end
                end
                BR2: begin
                    branch_taken  <= alu_o[31] | (alu_o == '0);
                    res_data      <= '0;
                    res_is_branch <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: behavioural ALU, reference model feeding an expected-result
// queue, and one task per scenario.
module tb_alu_issue_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        op_valid;
    logic        op_ready;
    logic [3:0]  op_code;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic [15:0] imm;
    logic [31:0] pc;
    logic [31:0] alu_i1;
    logic [31:0] alu_i2;
    logic [4:0]  alu_sel;
    logic [31:0] alu_o;
    logic        res_valid;
    logic        res_ready;
    logic [31:0] res_data;
    logic        res_is_branch;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        res_err;

    int vectors = 0;
    int miscompares = 0;

    // {err, is_branch, taken, target[31:0], data[31:0]}
    logic [66:0] exp_q[$];
    logic [4:0]  sel_q[$];
    int          lat_q[$];

    always #5 clk = ~clk;

    alu_issue_ctrl dut (
        .clk(clk), .reset(reset), .op_valid(op_valid), .op_ready(op_ready),
        .op_code(op_code), .rs_val(rs_val), .rt_val(rt_val), .imm(imm), .pc(pc),
        .alu_i1(alu_i1), .alu_i2(alu_i2), .alu_sel(alu_sel), .alu_o(alu_o),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_is_branch(res_is_branch), .branch_taken(branch_taken),
        .branch_target(branch_target), .res_err(res_err)
    );

    function automatic logic [31:0] rol(input logic [31:0] x, input logic [2:0] s);
        logic [63:0] d;
        d = {x, x};
        return d[63 - s -: 32];
    endfunction

    function automatic logic [31:0] ror(input logic [31:0] x, input logic [2:0] s);
        logic [63:0] d;
        d = {x, x};
        return d[31 + s -: 32];
    endfunction

    always_comb begin
        case (alu_sel)
            5'b10000, 5'b10001, 5'b10101, 5'b01000: alu_o = alu_i1 + alu_i2;
            5'b10011, 5'b00111: alu_o = ~(alu_i1 | alu_i2);
            5'b00010: alu_o = ~alu_i2;
            5'b00000: alu_o = rol(alu_i2, alu_i1[2:0]);
            5'b00001: alu_o = ror(alu_i2, alu_i1[2:0]);
            5'b01001: alu_o = alu_i1 - alu_i2;
            default:  alu_o = '0;
        endcase
    end

    function automatic logic [66:0] model(input logic [3:0] op, input logic [31:0] rs,
                                          input logic [31:0] rt, input logic [31:0] p,
                                          input logic [15:0] im);
        logic [31:0] sx, d, t, df;
        logic err, br, tk;
        sx = {{16{im[15]}}, im};
        d = '0; t = '0; err = 1'b0; br = 1'b0; tk = 1'b0;
        df = rs - rt;
        case (op)
            4'd0: d = rs + rt;
            4'd1, 4'd2: d = rs + sx;
            4'd3: d = ~(rs | rt);
            4'd4: d = ~(rs | {16'h0000, im});
            4'd5: d = ~rt;
            4'd6: d = rol(rt, rs[2:0]);
            4'd7: d = ror(rt, rs[2:0]);
            4'd8: begin t = p + sx; br = 1'b1; tk = df[31] | (df == 32'd0); end
            default: err = 1'b1;
        endcase
        return {err, br, tk, t, d};
    endfunction

    function automatic logic [4:0] exp_sel(input logic [3:0] op);
        case (op)
            4'd0: return 5'b10000;
            4'd1: return 5'b10001;
            4'd2: return 5'b10101;
            4'd3: return 5'b10011;
            4'd4: return 5'b00111;
            4'd5: return 5'b00010;
            4'd6: return 5'b00000;
            4'd7: return 5'b00001;
            4'd8: return 5'b01000;
            default: return 5'b11111;
        endcase
    endfunction

    // Driver: waits for op_ready, presents one op for one accept edge, records expectations.
    task automatic issue(input logic [3:0] op, input logic [31:0] rs, input logic [31:0] rt,
                         input logic [31:0] p, input logic [15:0] im);
        int n;
        n = 0;
        while (!op_ready && n < 20) begin
            @(posedge clk); #1; n++;
        end
        vectors++;
        if (op_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL issue_wait: op_ready=%b after %0d cycles, required 1", op_ready, n);
        end
        op_valid = 1'b1; op_code = op; rs_val = rs; rt_val = rt; pc = p; imm = im;
        exp_q.push_back(model(op, rs, rt, p, im));
        sel_q.push_back(exp_sel(op));
        lat_q.push_back(op > 4'd8 ? 1 : (op == 4'd8 ? 3 : 2));
        @(posedge clk); #1;
        op_valid = 1'b0;
    endtask

    // Scoreboard: waits for res_valid (bounded), pops and compares, optionally consumes.
    task automatic collect(input bit consume);
        logic [66:0] e;
        logic [4:0]  es;
        int          el, n;
        e = exp_q.pop_front(); es = sel_q.pop_front(); el = lat_q.pop_front();
        n = 1;
        while (!res_valid && n < 8) begin
            if (n == 1) begin
                vectors++;
                if (alu_sel !== es) begin
                    miscompares++;
                    $display("FAIL exec_sel: alu_sel=%b, required %b", alu_sel, es);
                end
            end
            if (n == 2) begin
                vectors++;
                if (alu_sel !== 5'b01001) begin
                    miscompares++;
                    $display("FAIL br2_sel: alu_sel=%b, required 01001", alu_sel);
                end
            end
            @(posedge clk); #1; n++;
        end
        vectors++;
        if (n !== el || res_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL latency: res_valid=%b after %0d edges, required 1 after %0d", res_valid, n, el);
        end
        vectors++;
        if ({res_err, res_is_branch, branch_taken, res_data} !== {e[66:64], e[31:0]}) begin
            miscompares++;
            $display("FAIL result: err/br/tk=%b%b%b data=%h, required %b data=%h",
                     res_err, res_is_branch, branch_taken, res_data, e[66:64], e[31:0]);
        end
        if (e[65]) begin
            vectors++;
            if (branch_target !== e[63:32]) begin
                miscompares++;
                $display("FAIL target: branch_target=%h, required %h", branch_target, e[63:32]);
            end
        end
        vectors++;
        if ({alu_sel, alu_i1, alu_i2, op_ready} !== {5'b11111, 64'h0, 1'b0}) begin
            miscompares++;
            $display("FAIL done_idle_alu: sel=%b i1=%h i2=%h op_ready=%b, required 11111/0/0/0",
                     alu_sel, alu_i1, alu_i2, op_ready);
        end
        if (consume) begin
            res_ready = 1'b1;
            @(posedge clk); #1;
            res_ready = 1'b0;
            vectors++;
            if (res_valid !== 1'b0 || op_ready !== 1'b1) begin
                miscompares++;
                $display("FAIL consume: res_valid=%b op_ready=%b, required 0/1", res_valid, op_ready);
            end
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        vectors++;
        if ({op_ready, res_valid, res_data, res_is_branch, branch_taken, branch_target, res_err,
             alu_sel, alu_i1, alu_i2} !== {1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 5'b11111, 64'h0}) begin
            miscompares++;
            $display("FAIL %s: rdy=%b vld=%b data=%h br=%b tk=%b tgt=%h err=%b sel=%b i1=%h i2=%h, required reset values",
                     tag, op_ready, res_valid, res_data, res_is_branch, branch_taken, branch_target,
                     res_err, alu_sel, alu_i1, alu_i2);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; op_valid = 1'b0; res_ready = 1'b0;
        op_code = '0; rs_val = '0; rt_val = '0; imm = '0; pc = '0;
        #1;
        check_reset_outputs("reset_state");
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk); #1;
        check_reset_outputs("after_reset");
    endtask

    task automatic test_add();
        issue(4'd0, 32'd5, 32'd7, 32'h0, 16'h0);
        collect(1'b1);
    endtask

    task automatic test_lw_sw();
        issue(4'd1, 32'h1000, 32'h0, 32'h0, 16'hFFFC);
        vectors++;
        if (alu_i2 !== 32'hFFFFFFFC || alu_i1 !== 32'h1000) begin
            miscompares++;
            $display("FAIL lw_operands: i1=%h i2=%h, required 00001000/fffffffc", alu_i1, alu_i2);
        end
        collect(1'b1);
        issue(4'd2, 32'h1000, 32'h0, 32'h0, 16'hFFFC);
        collect(1'b1);
        issue(4'd4, 32'h0F0F0000, 32'h0, 32'h0, 16'h8001);
        vectors++;
        if (alu_i2 !== 32'h00008001) begin
            miscompares++;
            $display("FAIL nori_zext: i2=%h, required 00008001", alu_i2);
        end
        collect(1'b1);
    endtask

    task automatic test_rotate_not();
        issue(4'd6, 32'd3, 32'h80000001, 32'h0, 16'h0);
        collect(1'b1);
        issue(4'd7, 32'd3, 32'h80000001, 32'h0, 16'h0);
        collect(1'b1);
        issue(4'd5, 32'hDEADBEEF, 32'h0, 32'h0, 16'h0);
        vectors++;
        if (alu_i1 !== 32'h0) begin
            miscompares++;
            $display("FAIL not_i1: i1=%h, required 0", alu_i1);
        end
        collect(1'b1);
        issue(4'd3, 32'h0000FFFF, 32'hFF000000, 32'h0, 16'h0);
        collect(1'b1);
    endtask

    task automatic test_bleu();
        issue(4'd8, 32'd4, 32'd4, 32'h100, 16'h0010);
        collect(1'b1);
        issue(4'd8, 32'd9, 32'd4, 32'h100, 16'h0010);
        collect(1'b1);
        issue(4'd8, 32'd1, 32'd2, 32'h00000008, 16'hFFF0);
        collect(1'b1);
    endtask

    task automatic test_illegal_hold();
        issue(4'd12, 32'h11, 32'h22, 32'h33, 16'h44);
        collect(1'b0);
        op_valid = 1'b1; op_code = 4'd0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            vectors++;
            if ({res_valid, res_err, res_data, op_ready, res_is_branch} !== {1'b1, 1'b1, 32'h0, 1'b0, 1'b0}) begin
                miscompares++;
                $display("FAIL illegal_hold[%0d]: vld=%b err=%b data=%h rdy=%b, required 1/1/0/0",
                         i, res_valid, res_err, res_data, op_ready);
            end
        end
        op_valid = 1'b0;
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
        vectors++;
        if (res_valid !== 1'b0 || op_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL illegal_release: vld=%b rdy=%b, required 0/1", res_valid, op_ready);
        end
    endtask

    task automatic test_reset_in_br2();
        int seen;
        issue(4'd8, 32'd4, 32'd4, 32'h100, 16'h0010);
        exp_q.delete(); sel_q.delete(); lat_q.delete();
        @(posedge clk); #1;
        vectors++;
        if (alu_sel !== 5'b01001) begin
            miscompares++;
            $display("FAIL br2_before_reset: alu_sel=%b, required 01001", alu_sel);
        end
        reset = 1'b1;
        #1;
        check_reset_outputs("async_reset_br2");
        @(posedge clk); #1;
        reset = 1'b0;
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (res_valid) seen++;
        end
        vectors++;
        if (seen !== 0) begin
            miscompares++;
            $display("FAIL discarded_op: res_valid seen %0d cycles, required 0", seen);
        end
        check_reset_outputs("idle_after_reset");
        issue(4'd0, 32'd100, 32'hFFFFFFFF, 32'h0, 16'h0);
        collect(1'b1);
    endtask

    task automatic test_back_to_back();
        int cnt;
        cnt = 0;
        op_valid = 1'b1; op_code = 4'd0; rs_val = 32'd1; rt_val = 32'd2; res_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (res_valid) begin
                cnt++;
                vectors++;
                if (res_data !== 32'd3) begin
                    miscompares++;
                    $display("FAIL b2b_data: res_data=%h, required 3", res_data);
                end
            end
        end
        op_valid = 1'b0; res_ready = 1'b0;
        @(posedge clk); #1;
        vectors++;
        if (cnt !== 4) begin
            miscompares++;
            $display("FAIL b2b_throughput: %0d results in 12 edges, required 4", cnt);
        end
    endtask

    task automatic test_random();
        logic [3:0] op;
        logic [31:0] rs, rt;
        for (int i = 0; i < 40; i++) begin
            op = 4'($urandom_range(0, 10));
            if (op == 4'd9) op = 4'($urandom_range(9, 15));
            rs = $urandom();
            rt = $urandom();
            if (op == 4'd8) begin
                rs = 32'($urandom_range(0, 15));
                rt = 32'($urandom_range(0, 15));
            end
            issue(op, rs, rt, $urandom(), 16'($urandom_range(0, 65535)));
            collect(1'b1);
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_lw_sw();
        test_rotate_not();
        test_bleu();
        test_illegal_hold();
        test_reset_in_br2();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
